dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 41 ++++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem_responder slice: FSM state and operation encodings.
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle. dmem_err exists only with DMEM_RESPONDER_ERR_EN.
//
// Handshake: the initiator raises dmem_read and/or dmem_write with address, wdata and
// byte_enable stable and holds them until it sees dmem_resp; the responder samples the
// request once in IDLE, ignores the inputs afterwards, and answers with a single-cycle
// dmem_resp pulse, dmem_rdata being valid in that cycle. Dropping the request in the
// cycle after dmem_resp (or presenting the next one) is the initiator's choice.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [BE_W-1:0]   dmem_byte_enable;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

`ifdef DMEM_RESPONDER_ERR_EN
  logic              dmem_err;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp, dmem_err
  );
  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp, dmem_err
  );
`else
  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );
  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Byte-enabled single-port word storage: synchronous write, combinational read, never reset.
module dmem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: request latches, IDLE/BUSY/RESP FSM, latency counter.
// Optional out-of-range error reporting is enabled by defining DMEM_RESPONDER_ERR_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_responder_if.slave bus,
  output state_e dbg_state_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        req;
  logic        req_err;
  logic        unused_addr_bits;
  logic [31:0] arr_rdata;
  logic [31:0] rd_word;
  logic        arr_we;

  assign req = bus.dmem_read | bus.dmem_write;

`ifdef DMEM_RESPONDER_ERR_EN
  assign req_err          = |bus.dmem_address[31:IDX_W+2];
  assign unused_addr_bits = ^bus.dmem_address[1:0];
`else
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{bus.dmem_address[31:IDX_W+2], bus.dmem_address[1:0]};
`endif

  // Out-of-range reads return zero; the stored word is never consulted.
  assign rd_word = err_q ? 32'h0 : arr_rdata;
  assign arr_we  = (state_q == S_RESP) && (op_q == OP_WRITE) && !err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = bus.dmem_write ? OP_WRITE : OP_READ;
          idx_d   = bus.dmem_address[IDX_W+1:2];
          wdata_d = bus.dmem_wdata;
          be_d    = bus.dmem_byte_enable;
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is shown live in RESP and captured so it holds until the next read response.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == S_RESP) && (op_q == OP_READ)) rdata_d = rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .idx_i   (idx_q),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign bus.dmem_resp  = (state_q == S_RESP);
  assign bus.dmem_rdata = rdata_d;
`ifdef DMEM_RESPONDER_ERR_EN
  assign bus.dmem_err   = (state_q == S_RESP) && err_q;
`endif
  assign dbg_state_o    = state_e'(state_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked every cycle against
// a transaction-level model (due-cycle scheduling plus a word array), with directed cases.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();
  state_e dbg0, dbg1, dbg2;

  logic        rd_v    [NI];
  logic        wr_v    [NI];
  logic [31:0] addr_v  [NI];
  logic [31:0] wdata_v [NI];
  logic [3:0]  be_v    [NI];
  logic        resp_w  [NI];
  logic [31:0] rdata_w [NI];
  logic        err_w   [NI];

  assign bus0.dmem_read = rd_v[0];  assign bus0.dmem_write = wr_v[0];
  assign bus0.dmem_address = addr_v[0]; assign bus0.dmem_wdata = wdata_v[0];
  assign bus0.dmem_byte_enable = be_v[0];
  assign bus1.dmem_read = rd_v[1];  assign bus1.dmem_write = wr_v[1];
  assign bus1.dmem_address = addr_v[1]; assign bus1.dmem_wdata = wdata_v[1];
  assign bus1.dmem_byte_enable = be_v[1];
  assign bus2.dmem_read = rd_v[2];  assign bus2.dmem_write = wr_v[2];
  assign bus2.dmem_address = addr_v[2]; assign bus2.dmem_wdata = wdata_v[2];
  assign bus2.dmem_byte_enable = be_v[2];

  assign resp_w[0] = bus0.dmem_resp; assign rdata_w[0] = bus0.dmem_rdata;
  assign resp_w[1] = bus1.dmem_resp; assign rdata_w[1] = bus1.dmem_rdata;
  assign resp_w[2] = bus2.dmem_resp; assign rdata_w[2] = bus2.dmem_rdata;
`ifdef DMEM_RESPONDER_ERR_EN
  assign err_w[0] = bus0.dmem_err; assign err_w[1] = bus1.dmem_err; assign err_w[2] = bus2.dmem_err;
`else
  assign err_w[0] = 1'b0; assign err_w[1] = 1'b0; assign err_w[2] = 1'b0;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state_o(dbg0));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state_o(dbg1));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state_o(dbg2));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- reference model ----------------
  // A request seen while no transaction is outstanding is due LATENCY cycles later;
  // reads sample the model word at that point, writes merge into it when it completes.
  logic [31:0] mem_m    [NI][1024];
  bit          pend_m   [NI];
  int          due_m    [NI];
  bit          pw_m     [NI];
  bit          perr_m   [NI];
  logic [9:0]  pidx_m   [NI];
  logic [31:0] pd_m     [NI];
  logic [3:0]  pbe_m    [NI];
  logic [31:0] exp_rd_m [NI];
  bit          exp_resp;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        pend_m[k]   = 1'b0;
        exp_rd_m[k] = 32'h0;
        chk($sformatf("rst_resp%0d", k), 32'(resp_w[k]), 32'h0);
        chk($sformatf("rst_rdata%0d", k), rdata_w[k], 32'h0);
      end else begin
        exp_resp = pend_m[k] && (due_m[k] == cyc);
        if (exp_resp && !pw_m[k]) exp_rd_m[k] = perr_m[k] ? 32'h0 : mem_m[k][pidx_m[k]];
        chk($sformatf("resp%0d", k), 32'(resp_w[k]), 32'(exp_resp));
        chk($sformatf("rdata%0d", k), rdata_w[k], exp_rd_m[k]);
`ifdef DMEM_RESPONDER_ERR_EN
        chk($sformatf("err%0d", k), 32'(err_w[k]), 32'(exp_resp && perr_m[k]));
`endif
        if (exp_resp) begin
          if (pw_m[k] && !perr_m[k])
            mem_m[k][pidx_m[k]] = merge(mem_m[k][pidx_m[k]], pd_m[k], pbe_m[k]);
          pend_m[k] = 1'b0;
        end else if (!pend_m[k] && (rd_v[k] || wr_v[k])) begin
          pend_m[k] = 1'b1;
          due_m[k]  = cyc + lat_of(k);
          pw_m[k]   = wr_v[k];
          pidx_m[k] = addr_v[k][11:2];
          pd_m[k]   = wdata_v[k];
          pbe_m[k]  = be_v[k];
`ifdef DMEM_RESPONDER_ERR_EN
          perr_m[k] = (addr_v[k] >> 12) != 32'h0;
`else
          perr_m[k] = 1'b0;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    rd_v[k] = 1'b0; wr_v[k] = 1'b0;
    addr_v[k] = 32'h0; wdata_v[k] = 32'h0; be_v[k] = 4'h0;
  endtask

  task automatic drive(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    rd_v[k] = r; wr_v[k] = w; addr_v[k] = a; wdata_v[k] = d; be_v[k] = be;
  endtask

  // Called just after a rising edge; returns one cycle after the response edge.
  task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rdat, output int lat, output logic errv);
    int start;
    bit got = 1'b0;
    rdat = 32'h0; lat = -1; errv = 1'b0;
    drive(k, r, w, a, d, be);
    start = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_w[k]) begin
        got = 1'b1; rdat = rdata_w[k]; lat = cyc - start; errv = err_w[k];
      end
    end
    chk($sformatf("resp_seen%0d", k), 32'(got), 32'h1);
    @(posedge clk); #1;
    idle(k);
  endtask

  task automatic rst_mid(input int k, input logic [31:0] a, input logic [31:0] d, input int hold);
    drive(k, 1'b0, 1'b1, a, d, 4'hF);
    repeat (1 + hold) begin @(posedge clk); #1; end
    rst = 1'b1;
    idle(k);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned idx = $urandom_range(0, 15);
    int unsigned hi  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
    int unsigned sh  = $urandom_range(12, 28);
    return (32'(hi) << sh) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic rnd_txn(input int k);
    logic [31:0] rdat;
    int          lat;
    logic        errv;
    bit r = 1'(($urandom_range(0, 1)));
    bit w = r ? ($urandom_range(0, 3) == 0) : 1'b1;
    txn(k, r, w, rnd_addr(), $urandom, 4'($urandom_range(0, 15)), rdat, lat, errv);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rdat;
    int          lat;
    logic        errv;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) idle(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state0", 32'(dbg0), 32'(IDLE));
    chk("rst_state1", 32'(dbg1), 32'(IDLE));
    chk("rst_state2", 32'(dbg2), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // First request right after reset release, then preload the random working set.
    txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rdat, lat, errv);
    chk("first_after_rst_lat", 32'(lat), 32'd2);
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rdat, lat, errv);
    chk("wr_rd_lat", 32'(lat), 32'd2);
    chk("wr_rd_data", rdat, 32'hDEADBEEF);

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++)
        txn(k, 1'b0, 1'b1, 32'(i) << 2, 32'hC0DE0000 | 32'(i), 4'hF, rdat, lat, errv);

    // Byte lanes.
    txn(0, 1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, rdat, lat, errv);
    txn(0, 1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0100, rdat, lat, errv);
    txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, rdat, lat, errv);
    chk("byte_lane", rdat, 32'h11BB3344);

    // Zero byte-enable write still completes and changes nothing.
    txn(0, 1'b0, 1'b1, 32'h80, 32'h0, 4'h0, rdat, lat, errv);
    chk("be0_lat", 32'(lat), 32'd2);
    txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, rdat, lat, errv);
    chk("be0_data", rdat, 32'h11BB3344);

    // Read and write together act as a write; rdata keeps the previous read value.
    txn(0, 1'b1, 1'b1, 32'h10, 32'h5, 4'hF, rdat, lat, errv);
    chk("rw_rdata_held", rdat, 32'h11BB3344);
    chk("rw_rdata_after", rdata_w[0], 32'h11BB3344);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rdat, lat, errv);
    chk("rw_wrote", rdat, 32'h5);

    // Reset one cycle after acceptance aborts the write.
    txn(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rdat, lat, errv);
    rst_mid(0, 32'h20, 32'hFFFFFFFF, 0);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rdat, lat, errv);
    chk("midrst_lat", 32'(lat), 32'd2);
    chk("midrst_data", rdat, 32'h0BADF00D);

    // Address aliasing versus out-of-range error.
    txn(0, 1'b0, 1'b1, 32'h4, 32'h12345678, 4'hF, rdat, lat, errv);
`ifdef DMEM_RESPONDER_ERR_EN
    txn(0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, rdat, lat, errv);
    chk("err_flag", 32'(errv), 32'h1);
    chk("err_rdata", rdat, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h1004, 32'hFFFF0000, 4'hF, rdat, lat, errv);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rdat, lat, errv);
    chk("err_untouched", rdat, 32'h12345678);
`else
    txn(0, 1'b0, 1'b1, 32'h1004, 32'h87654321, 4'hF, rdat, lat, errv);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rdat, lat, errv);
    chk("alias_data", rdat, 32'h87654321);
`endif

    // Back-to-back reads at the latency extremes (index 1 was written by the preload).
    for (int k = 1; k < NI; k++)
      for (int i = 2; i < 10; i++) begin
        txn(k, 1'b1, 1'b0, 32'(i) << 2, 32'h0, 4'h0, rdat, lat, errv);
        chk($sformatf("sweep_lat%0d", k), 32'(lat), 32'(lat_of(k)));
        chk($sformatf("sweep_data%0d", k), rdat, 32'hC0DE0000 | 32'(i));
      end

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0)
        rst_mid(0, rnd_addr(), $urandom, $urandom_range(0, 1));
      else
        rnd_txn(0);
    end
    for (int n = 0; n < 80; n++) rnd_txn(1);
    for (int n = 0; n < 30; n++) rnd_txn(2);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
